// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pulls SYNC/LEN/payload/CHK frames out of a UART byte stream,
// holds the payload in a small buffer and replays it over a valid/ready byte
// stream only once the XOR checksum has matched, so downstream never sees a bad frame.
module uart_frame_parser #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] symbol_i,
    input  logic       newSymbol_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       last_o,
    input  logic       ready_i,
    output logic       frameOk_o,
    output logic       frameErr_o,
    output logic [1:0] errCode_o
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_PAYLOAD,
        GET_CHK,
        OUTPUT
    } state_t;

    typedef enum logic [1:0] {
        ERR_LEN     = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_t;

    state_t        state, state_next;
    logic [LW-1:0] len, len_next;
    logic [LW-1:0] idx, idx_next;
    logic [LW-1:0] rd, rd_next;
    logic [7:0]    chk_acc, chk_acc_next;
    logic [TW-1:0] timer, timer_next;
    logic          frame_ok, frame_ok_next;
    logic          frame_err, frame_err_next;
    logic [1:0]    err_code, err_code_next;
    logic          wr_en;
    logic          timed_state;

    // The buffer holds no control information, so it needs no reset: rd only
    // ever reads entries written during the current frame.
    logic [7:0] payload_mem [0:(1 << IW) - 1];

    // State, counters, checksum, timer and event pulses; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            rd        <= '0;
            chk_acc   <= '0;
            timer     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_next;
            len       <= len_next;
            idx       <= idx_next;
            rd        <= rd_next;
            chk_acc   <= chk_acc_next;
            timer     <= timer_next;
            frame_ok  <= frame_ok_next;
            frame_err <= frame_err_next;
            err_code  <= err_code_next;
        end
    end

    // Payload capture while a frame is being received.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            payload_mem[idx[IW-1:0]] <= symbol_i;
        end
    end

    // Frame parser next-state logic plus the inter-symbol timeout that guards
    // every receiving state; a symbol in the expiry cycle beats the timeout.
    always_comb begin
        state_next     = state;
        len_next       = len;
        idx_next       = idx;
        rd_next        = rd;
        chk_acc_next   = chk_acc;
        timer_next     = '0;
        frame_ok_next  = 1'b0;
        frame_err_next = 1'b0;
        err_code_next  = err_code;
        wr_en          = 1'b0;
        timed_state    = (state == GET_LEN) || (state == GET_PAYLOAD) || (state == GET_CHK);

        case (state)
            IDLE: begin
                if (newSymbol_i && (symbol_i == SYNC_BYTE)) begin
                    state_next = GET_LEN;
                end
            end
            GET_LEN: begin
                if (newSymbol_i) begin
                    if ((symbol_i == 8'd0) || (int'(symbol_i) > MAX_LEN)) begin
                        frame_err_next = 1'b1;
                        err_code_next  = ERR_LEN;
                        state_next     = IDLE;
                    end else begin
                        len_next     = LW'(symbol_i);
                        chk_acc_next = symbol_i;
                        idx_next     = '0;
                        state_next   = GET_PAYLOAD;
                    end
                end
            end
            GET_PAYLOAD: begin
                if (newSymbol_i) begin
                    wr_en        = 1'b1;
                    chk_acc_next = chk_acc ^ symbol_i;
                    idx_next     = idx + LW'(1);
                    if (idx == len - LW'(1)) begin
                        state_next = GET_CHK;
                    end
                end
            end
            GET_CHK: begin
                if (newSymbol_i) begin
                    if (symbol_i == chk_acc) begin
                        frame_ok_next = 1'b1;
                        rd_next       = '0;
                        state_next    = OUTPUT;
                    end else begin
                        frame_err_next = 1'b1;
                        err_code_next  = ERR_CHK;
                        state_next     = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (newSymbol_i) begin
                    frame_err_next = 1'b1;
                    err_code_next  = ERR_OVERRUN;
                end
                if (ready_i) begin
                    rd_next = rd + LW'(1);
                    if (rd == len - LW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (timed_state && !newSymbol_i) begin
            if (timer == TIMER_LAST) begin
                frame_err_next = 1'b1;
                err_code_next  = ERR_TIMEOUT;
                state_next     = IDLE;
            end else begin
                timer_next = timer + TW'(1);
            end
        end
    end

    // Output stream is driven straight from the buffer while replaying a frame.
    always_comb begin
        valid_o    = (state == OUTPUT);
        data_o     = valid_o ? payload_mem[rd[IW-1:0]] : 8'd0;
        last_o     = valid_o && (rd == len - LW'(1));
        frameOk_o  = frame_ok;
        frameErr_o = frame_err;
        errCode_o  = err_code;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: directed frames drive the parser while a
// scoreboard monitor matches every event pulse and every transferred byte
// against expectations queued by the stimulus.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] symbol;
    logic       new_symbol;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        int         cyc;
    } event_t;

    typedef struct {
        logic [7:0] value;
        logic       last;
        int         cyc;
    } beat_t;

    event_t     evq[$];
    beat_t      dq[$];
    logic [7:0] pay[$];
    int         cyc = 0;
    int         last_edge = 0;
    int         vectors = 0;
    int         miscompares = 0;

    uart_frame_parser #(
        .MAX_LEN(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .symbol_i(symbol),
        .newSymbol_i(new_symbol),
        .data_o(data),
        .valid_o(valid),
        .last_o(last),
        .ready_i(ready),
        .frameOk_o(frame_ok),
        .frameErr_o(frame_err),
        .errCode_o(err_code)
    );

    // Free-running clock and an edge counter used to time-stamp expectations.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One symbol: strobe set up on the falling edge, sampled on the next rising edge.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clk);
        symbol     = value;
        new_symbol = 1'b1;
        @(posedge clk);
        #1;
        new_symbol = 1'b0;
        last_edge  = cyc;
    endtask

    task automatic pushErr(input logic [1:0] code, input int at);
        event_t e;
        e.is_err = 1'b1;
        e.code   = code;
        e.cyc    = at;
        evq.push_back(e);
    endtask

    task automatic pushOk(input int at);
        event_t e;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.cyc    = at;
        evq.push_back(e);
    endtask

    task automatic pushData(input logic [7:0] value, input logic is_last, input int at);
        beat_t b;
        b.value = value;
        b.last  = is_last;
        b.cyc   = at;
        dq.push_back(b);
    endtask

    // Sends SYNC, LEN, the bytes in pay and chk; queues the good-frame response.
    // With timed set, bytes are expected back-to-back starting the cycle after CHK.
    task automatic sendFrame(input logic [7:0] chk, input bit timed);
        applyStimulus(8'hA5);
        applyStimulus(8'(pay.size()));
        foreach (pay[i]) applyStimulus(pay[i]);
        applyStimulus(chk);
        pushOk(last_edge);
        foreach (pay[i]) pushData(pay[i], (i == pay.size() - 1), timed ? last_edge + i : -1);
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while ((evq.size() + dq.size() != 0) && (n < max_cycles)) begin
            @(negedge clk);
            n++;
        end
        if (evq.size() + dq.size() != 0) begin
            checkOutput("drain_pending", evq.size() + dq.size(), 0);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkHold();
        @(negedge clk);
        checkOutput("hold_valid", valid, 1'b1);
        checkOutput("hold_data", data, 8'h0A);
        checkOutput("hold_last", last, 1'b0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_data"}, data, 8'h00);
        checkOutput({tag, "_valid"}, valid, 1'b0);
        checkOutput({tag, "_last"}, last, 1'b0);
        checkOutput({tag, "_ok"}, frame_ok, 1'b0);
        checkOutput({tag, "_err"}, frame_err, 1'b0);
        checkOutput({tag, "_code"}, err_code, 2'd0);
    endtask

    // Scoreboard monitor: pops an expectation for every pulse and every transfer.
    always @(negedge clk) begin
        event_t e;
        beat_t  b;
        if (rst_n) begin
            if (frame_ok && frame_err) begin
                checkOutput("ok_err_together", {frame_ok, frame_err}, 2'b00);
            end
            if (frame_ok || frame_err) begin
                if (evq.size() == 0) begin
                    checkOutput("unexpected_event", {frame_ok, frame_err}, 2'b00);
                end else begin
                    e = evq.pop_front();
                    checkOutput("event_kind", frame_err, e.is_err);
                    if (e.is_err) checkOutput("err_code", err_code, e.code);
                    checkOutput("event_cycle", cyc, e.cyc);
                end
            end
            if (valid && (dq.size() == 0)) begin
                checkOutput("unexpected_valid", valid, 1'b0);
            end else if (valid && ready) begin
                b = dq.pop_front();
                checkOutput("data", data, b.value);
                checkOutput("last", last, b.last);
                if (b.cyc >= 0) checkOutput("data_cycle", cyc, b.cyc);
            end
        end
    end

    // Watchdog so the run always ends even if the design wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d events and %0d bytes pending", evq.size(), dq.size());
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        rst_n      = 1'b0;
        symbol     = 8'h00;
        new_symbol = 1'b0;
        ready      = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] good frame A5 03 11 22 33 03");
        pay = '{8'h11, 8'h22, 8'h33};
        sendFrame(8'h03, 1'b1);
        waitDrain(20);

        $display("[TB] bad checksum A5 02 10 20 33, then a good frame");
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        applyStimulus(8'h33);
        pushErr(2'd1, last_edge);
        waitDrain(20);
        pay = '{8'h11, 8'h22, 8'h33};
        sendFrame(8'h03, 1'b1);
        waitDrain(20);

        $display("[TB] length limits");
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        pushErr(2'd0, last_edge);
        waitDrain(20);
        applyStimulus(8'hA5);
        applyStimulus(8'h11);
        pushErr(2'd0, last_edge);
        waitDrain(20);
        // A bad LEN equal to SYNC must not restart a frame by itself.
        applyStimulus(8'hA5);
        applyStimulus(8'hA5);
        pushErr(2'd0, last_edge);
        pay = '{8'h7E};
        sendFrame(8'h7F, 1'b1);
        waitDrain(20);
        // 16-byte payload 01..10: XOR of 01..0F is 00, ^10 ^LEN(10) gives CHK 00.
        pay.delete();
        for (int i = 1; i <= 16; i++) pay.push_back(8'(i));
        sendFrame(8'h00, 1'b1);
        waitDrain(40);

        $display("[TB] timeout after 50 silent cycles");
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h10);
        pushErr(2'd2, last_edge + 50);
        waitDrain(80);

        $display("[TB] symbol arriving in the expiry cycle");
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h10);
        repeat (49) @(negedge clk);
        applyStimulus(8'h20);
        applyStimulus(8'h32);
        pushOk(last_edge);
        pushData(8'h10, 1'b0, last_edge);
        pushData(8'h20, 1'b1, last_edge + 1);
        waitDrain(20);

        $display("[TB] backpressure with an overrun symbol");
        @(posedge clk);
        #1;
        ready = 1'b0;
        pay = '{8'h0A, 8'h0B, 8'h0C};
        sendFrame(8'h0E, 1'b0);
        repeat (4) checkHold();
        applyStimulus(8'h55);
        pushErr(2'd3, last_edge);
        repeat (5) checkHold();
        @(posedge clk);
        #1;
        ready = 1'b1;
        waitDrain(20);

        $display("[TB] reset in the middle of a payload");
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pay = '{8'hAA, 8'hBB};
        sendFrame(8'h13, 1'b1);
        waitDrain(20);

        checkOutput("events_left", evq.size(), 0);
        checkOutput("bytes_left", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
